// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: receiver FSM state encoding.
package uart_rx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word-fall-through FIFO; head word is visible on rdata while non-empty.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // A pop frees the slot this cycle, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign level   = count;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver: synchronizer, bit-timing FSM, sticky error flags and a
// byte FIFO for the CPU read path.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DEPTH        = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   rxd,
  input  logic                   rx_rd,
  input  logic                   err_clr,
  output logic [7:0]             rx_data,
  output logic                   rx_valid,
  output logic [$clog2(DEPTH):0] rx_level,
  output logic                   frame_err,
  output logic                   overrun,
  output logic [2:0]             rx_state
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  rx_state_e     state;
  logic          rx_m, rx_s, rx_q;
  logic [1:0]    warm;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          push_req, fe_set, ovr_set;
  logic          fifo_full, fifo_empty;

  // Handshake: rx_valid=1 means rx_data holds the oldest byte; a cycle with
  // rx_rd=1 and rx_valid=1 consumes it. rx_rd with rx_valid=0 is a no-op.
  assign rx_state = state;
  assign push_req = (state == ST_STOP) && (cnt == '0) && rx_s;
  assign fe_set   = (state == ST_STOP) && (cnt == '0) && !rx_s;
  assign ovr_set  = push_req && fifo_full && !rx_rd;
  assign rx_valid = ~fifo_empty;

  // Sync flops preset high so reset looks like an idle line. warm holds off
  // edge detection until rx_q/rx_s both reflect the real pin.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_q <= 1'b1;
      warm <= 2'd0;
    end else begin
      rx_m <= rxd;
      rx_s <= rx_m;
      rx_q <= rx_s;
      if (warm != 2'd3) warm <= warm + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (warm == 2'd3 && rx_q && !rx_s) begin
            cnt   <= HALF_LOAD;
            state <= ST_START;
          end
        end
        ST_START: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else if (!rx_s) begin
            cnt     <= FULL_LOAD;
            bit_idx <= '0;
            state   <= ST_DATA;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - CW'(1);
          end else begin
            shift_reg <= {rx_s, shift_reg[7:1]};
            cnt       <= FULL_LOAD;
            bit_idx   <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (cnt != '0) cnt <= cnt - CW'(1);
          else           state <= rx_s ? ST_IDLE : ST_BREAK;
        end
        ST_BREAK: begin
          if (rx_s) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A same-cycle set wins over err_clr.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= fe_set  | (frame_err & ~err_clr);
      overrun   <= ovr_set | (overrun   & ~err_clr);
    end
  end

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_req),
    .pop    (rx_rd),
    .wdata  (shift_reg),
    .rdata  (rx_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .level  (rx_level)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with CLKS_PER_BIT=16, DEPTH=4.
module tb_uart_rx_fifo;

  localparam int CPB = 16;
  localparam int DEP = 4;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rxd;
  logic       rx_rd;
  logic       err_clr;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [2:0] rx_level;
  logic       frame_err;
  logic       overrun;
  logic [2:0] rx_state;

  int checks = 0;
  int errors = 0;
  int valid_k;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .DEPTH(DEP)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .rxd       (rxd),
    .rx_rd     (rx_rd),
    .err_clr   (err_clr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_level  (rx_level),
    .frame_err (frame_err),
    .overrun   (overrun),
    .rx_state  (rx_state)
  );

  always #5 clk = ~clk;

  // Drives one full 10-bit frame starting at a negedge (k=0 is the start edge).
  // rd_at/clr_at pulse rx_rd/err_clr for the cycle following negedge k.
  // The stop-bit sample (push) cycle follows negedge k=154.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                            input int rd_at, input int clr_at);
    logic [9:0] bits;
    bits    = {stop_bit, data, 1'b0};
    valid_k = -1;
    for (int k = 0; k < 10*CPB; k++) begin
      @(negedge clk);
      if (rx_valid && valid_k < 0) valid_k = k;
      rxd     = bits[k/CPB];
      rx_rd   = (k == rd_at);
      err_clr = (k == clr_at);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_byte();
    @(negedge clk);
    rx_rd = 1'b1;
    @(negedge clk);
    rx_rd = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; rxd = 1'b1; rx_rd = 1'b0; err_clr = 1'b0;
    idle(3);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_data); end
    checks++; if (rx_level !== 3'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", rx_level); end
    checks++; if ({frame_err, overrun} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {frame_err, overrun}); end
    checks++; if (rx_state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", rx_state); end
    resetn = 1'b1;
    idle(5);
  endtask

  task automatic test_basic();
    send_frame(8'hA5, 1'b1, -1, -1);
    checks++; if (valid_k !== 155) begin errors++; $display("FAIL basic_latency got %0d exp 155", valid_k); end
    checks++; if (rx_data !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", rx_data); end
    checks++; if (rx_level !== 3'd1) begin errors++; $display("FAIL basic_level got %0d exp 1", rx_level); end
    checks++; if ({frame_err, overrun} !== 2'b00) begin errors++; $display("FAIL basic_flags got %b exp 00", {frame_err, overrun}); end
    pop_byte();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_pop_valid got %0b exp 0", rx_valid); end
    checks++; if (rx_level !== 3'd0) begin errors++; $display("FAIL basic_pop_level got %0d exp 0", rx_level); end
    pop_byte();
    checks++; if (rx_level !== 3'd0) begin errors++; $display("FAIL underflow_level got %0d exp 0", rx_level); end
    idle(10);
  endtask

  task automatic test_glitch();
    @(negedge clk);
    rxd = 1'b0;
    idle(6);
    rxd = 1'b1;
    idle(30);
    checks++; if (rx_state !== 3'd0) begin errors++; $display("FAIL glitch_state got %0d exp 0", rx_state); end
    checks++; if (rx_level !== 3'd0) begin errors++; $display("FAIL glitch_level got %0d exp 0", rx_level); end
    checks++; if ({frame_err, overrun} !== 2'b00) begin errors++; $display("FAIL glitch_flags got %b exp 00", {frame_err, overrun}); end
  endtask

  task automatic test_frame_err();
    // err_clr lands on the stop-sample cycle; the set must win.
    send_frame(8'h3C, 1'b0, -1, 154);
    err_clr = 1'b0;
    idle(2);
    checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL fe_set got %0b exp 1", frame_err); end
    checks++; if (rx_state !== 3'd4) begin errors++; $display("FAIL fe_break got %0d exp 4", rx_state); end
    checks++; if (rx_level !== 3'd0) begin errors++; $display("FAIL fe_nopush got %0d exp 0", rx_level); end
    idle(20*CPB);
    pulse_clr();
    idle(20*CPB);
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL fe_once got %0b exp 0", frame_err); end
    rxd = 1'b1;
    idle(2*CPB);
    checks++; if (rx_state !== 3'd0) begin errors++; $display("FAIL fe_idle got %0d exp 0", rx_state); end
    send_frame(8'h3C, 1'b1, -1, -1);
    idle(2);
    checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL fe_recover_data got %h exp 3c", rx_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL fe_recover_flag got %0b exp 0", frame_err); end
    pop_byte();
  endtask

  task automatic test_overrun();
    logic [7:0] exp_b;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, -1, -1);
    idle(2);
    checks++; if (rx_level !== 3'd4) begin errors++; $display("FAIL ovr_level got %0d exp 4", rx_level); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %0b exp 1", overrun); end
    for (int i = 1; i <= 4; i++) begin
      exp_b = 8'(i);
      checks++; if (rx_data !== exp_b) begin errors++; $display("FAIL ovr_read got %h exp %h", rx_data, exp_b); end
      pop_byte();
    end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_drained got %0b exp 0", rx_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %0b exp 1", overrun); end
    pulse_clr();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clr got %0b exp 0", overrun); end
    for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b1, -1, -1);
    send_frame(8'h15, 1'b1, 154, -1);
    rx_rd = 1'b0;
    idle(2);
    checks++; if (rx_level !== 3'd4) begin errors++; $display("FAIL full_pushpop_level got %0d exp 4", rx_level); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL full_pushpop_ovr got %0b exp 0", overrun); end
    for (int i = 0; i < 4; i++) begin
      exp_b = 8'h12 + 8'(i);
      checks++; if (rx_data !== exp_b) begin errors++; $display("FAIL full_pushpop_read got %h exp %h", rx_data, exp_b); end
      pop_byte();
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] bits;
    send_frame(8'h5A, 1'b1, -1, -1);
    bits = {1'b1, 8'h77, 1'b0};
    for (int k = 0; k < 70; k++) begin
      @(negedge clk);
      rxd = bits[k/CPB];
    end
    resetn = 1'b0;
    idle(3);
    checks++; if ({rx_valid, rx_data, rx_level, frame_err, overrun} !== 13'd0) begin
      errors++; $display("FAIL midreset_outputs got %h exp 0", {rx_valid, rx_data, rx_level, frame_err, overrun});
    end
    resetn = 1'b1;
    idle(7);
    rxd = 1'b1;
    idle(40);
    checks++; if (rx_state !== 3'd0) begin errors++; $display("FAIL midreset_state got %0d exp 0", rx_state); end
    checks++; if (rx_level !== 3'd0) begin errors++; $display("FAIL midreset_stray got %0d exp 0", rx_level); end
    send_frame(8'h12, 1'b1, -1, -1);
    idle(2);
    checks++; if (rx_data !== 8'h12) begin errors++; $display("FAIL midreset_data got %h exp 12", rx_data); end
    checks++; if (rx_level !== 3'd1) begin errors++; $display("FAIL midreset_level got %0d exp 1", rx_level); end
    pop_byte();
  endtask

  task automatic test_back_to_back();
    send_frame(8'h00, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b1, -1, -1);
    idle(2);
    checks++; if (rx_level !== 3'd2) begin errors++; $display("FAIL b2b_level got %0d exp 2", rx_level); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL b2b_first got %h exp 00", rx_data); end
    pop_byte();
    checks++; if (rx_data !== 8'hFF) begin errors++; $display("FAIL b2b_second got %h exp ff", rx_data); end
    pop_byte();
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty got %0b exp 0", rx_valid); end
  endtask

  task automatic test_wrap();
    logic [7:0] tbl [10];
    tbl = '{8'h3A, 8'hC5, 8'h81, 8'h7E, 8'h55, 8'hAA, 8'h0F, 8'hF0, 8'h96, 8'h69};
    for (int i = 0; i < 10; i++) begin
      send_frame(tbl[i], 1'b1, -1, -1);
      idle(2);
      checks++; if (rx_data !== tbl[i]) begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", i, rx_data, tbl[i]); end
      pop_byte();
      checks++; if (rx_level !== 3'd0) begin errors++; $display("FAIL wrap_level[%0d] got %0d exp 0", i, rx_level); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_glitch();
    test_frame_err();
    test_overrun();
    test_reset_mid();
    test_back_to_back();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
